// File: rtl/noc_credit_link_if.sv
// Link-level bundle for one direction of a credit-based NoC hop.
// The flit fields travel from the sending router to the receiving router.
// The credit travels back from the receiver to the sender.
interface noc_credit_link_if #(
    parameter int FLIT_WIDTH = 128,
    parameter int DEST_WIDTH = 6
);
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic                  send;
    logic                  credit;

    // Sender side: drives flits, receives credits
    modport master (
        output data,
        output dest,
        output is_tail,
        output send,
        input  credit
    );

    // Receiver side: accepts flits, returns credits
    modport slave (
        input  data,
        input  dest,
        input  is_tail,
        input  send,
        output credit
    );
endinterface

// File: rtl/noc_credit_link.sv
// Credit-based NoC link stage with an upstream protocol monitor.
// Flits move downstream and credits move upstream through NUM_PIPELINE
// register stages each. The monitor watches the upstream side of the link:
// it tracks credits, checks packet framing, and keeps sticky error flags
// and saturating flit/packet counters.
module noc_credit_link #(
    parameter int  FLIT_WIDTH        = 128,
    parameter int  DEST_WIDTH        = 6,
    parameter int  NUM_PIPELINE      = 0,
    parameter int  FLIT_BUFFER_DEPTH = 4,
    parameter int  STAT_WIDTH        = 32,
    localparam int CW                = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    noc_credit_link_if.slave      up,
    noc_credit_link_if.master     down,
    input  logic                  clear_stats,
    output logic [CW-1:0]         credits_avail,
    output logic                  err_overflow,
    output logic                  err_credit_excess,
    output logic                  err_dest_change,
    output logic [STAT_WIDTH-1:0] flit_count,
    output logic [STAT_WIDTH-1:0] pkt_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    localparam logic [CW-1:0] CREDIT_FULL = CW'(FLIT_BUFFER_DEPTH);

    logic                  send_evt;
    logic                  credit_evt;
    logic                  overflow_evt;
    logic                  excess_evt;
    logic                  dest_change_evt;
    logic [CW-1:0]         credit_cnt;
    logic [0:0]            state;
    logic [DEST_WIDTH-1:0] dest_latched;

    // ------------------------------------------------------------------
    // Pipelines in both directions
    // ------------------------------------------------------------------
    if (NUM_PIPELINE == 0) begin : g_wire
        assign down.send    = up.send;
        assign down.data    = up.data;
        assign down.dest    = up.dest;
        assign down.is_tail = up.is_tail;
        assign up.credit    = down.credit;
    end else begin : g_pipe
        logic [NUM_PIPELINE-1:0] send_q;
        logic [NUM_PIPELINE-1:0] tail_q;
        logic [NUM_PIPELINE-1:0] credit_q;
        logic [FLIT_WIDTH-1:0]   data_q [NUM_PIPELINE];
        logic [DEST_WIDTH-1:0]   dest_q [NUM_PIPELINE];

        // Forward shift register: flit fields advance one stage per cycle, never stalling
        always_ff @(posedge clk_noc or negedge rst_n) begin
            if (!rst_n) begin
                send_q <= '0;
                tail_q <= '0;
                for (int i = 0; i < NUM_PIPELINE; i++) begin
                    data_q[i] <= '0;
                    dest_q[i] <= '0;
                end
            end else begin
                send_q[0] <= up.send;
                tail_q[0] <= up.is_tail;
                data_q[0] <= up.data;
                dest_q[0] <= up.dest;
                for (int i = 1; i < NUM_PIPELINE; i++) begin
                    send_q[i] <= send_q[i-1];
                    tail_q[i] <= tail_q[i-1];
                    data_q[i] <= data_q[i-1];
                    dest_q[i] <= dest_q[i-1];
                end
            end
        end

        // Backward shift register: returning credits advance one stage per cycle
        always_ff @(posedge clk_noc or negedge rst_n) begin
            if (!rst_n) begin
                credit_q <= '0;
            end else begin
                credit_q[0] <= down.credit;
                for (int i = 1; i < NUM_PIPELINE; i++) begin
                    credit_q[i] <= credit_q[i-1];
                end
            end
        end

        assign down.send    = send_q[NUM_PIPELINE-1];
        assign down.is_tail = tail_q[NUM_PIPELINE-1];
        assign down.data    = data_q[NUM_PIPELINE-1];
        assign down.dest    = dest_q[NUM_PIPELINE-1];
        assign up.credit    = credit_q[NUM_PIPELINE-1];
    end

    // ------------------------------------------------------------------
    // Upstream monitor
    // ------------------------------------------------------------------
    // The monitor sees credits as the upstream router sees them, after the delay.
    assign send_evt        = up.send;
    assign credit_evt      = up.credit;
    assign overflow_evt    = send_evt && !credit_evt && (credit_cnt == '0);
    assign excess_evt      = credit_evt && !send_evt && (credit_cnt == CREDIT_FULL);
    assign dest_change_evt = send_evt && (state == ST_BODY) && (up.dest != dest_latched);

    // Credit counter: a send spends a credit and a returned credit refills one; on an error it holds
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CREDIT_FULL;
        end else if (send_evt && !credit_evt) begin
            if (credit_cnt != '0) begin
                credit_cnt <= credit_cnt - CW'(1);
            end
        end else if (credit_evt && !send_evt) begin
            if (credit_cnt != CREDIT_FULL) begin
                credit_cnt <= credit_cnt + CW'(1);
            end
        end
    end

    assign credits_avail = credit_cnt;

    // Framing FSM: a non-tail flit in IDLE opens a packet and fixes its destination
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dest_latched <= '0;
        end else if (send_evt) begin
            case (state)
                ST_IDLE: begin
                    if (!up.is_tail) begin
                        state        <= ST_BODY;
                        dest_latched <= up.dest;
                    end
                end
                ST_BODY: begin
                    if (up.is_tail) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a clear in the same cycle wins over a new error
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow      <= 1'b0;
            err_credit_excess <= 1'b0;
            err_dest_change   <= 1'b0;
        end else if (clear_stats) begin
            err_overflow      <= 1'b0;
            err_credit_excess <= 1'b0;
            err_dest_change   <= 1'b0;
        end else begin
            if (overflow_evt) begin
                err_overflow <= 1'b1;
            end
            if (excess_evt) begin
                err_credit_excess <= 1'b1;
            end
            if (dest_change_evt) begin
                err_dest_change <= 1'b1;
            end
        end
    end

    // Saturating flit and packet counters; a clear in the same cycle drops the event
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            flit_count <= '0;
            pkt_count  <= '0;
        end else if (clear_stats) begin
            flit_count <= '0;
            pkt_count  <= '0;
        end else begin
            if (send_evt && (flit_count != '1)) begin
                flit_count <= flit_count + STAT_WIDTH'(1);
            end
            if (send_evt && up.is_tail && (pkt_count != '1)) begin
                pkt_count <= pkt_count + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_noc_credit_link.sv
// Directed testbench for noc_credit_link.
// The main instance has two pipeline stages per direction. A second instance
// has no pipeline stages and is used to check the wire-through path.
module tb_noc_credit_link;

    localparam int FW    = 128;
    localparam int DW    = 6;
    localparam int NP    = 2;
    localparam int DEPTH = 4;
    localparam int SW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_noc;
    logic          rst_n;
    logic          clear_stats;

    logic [CW-1:0] credits_a, credits_b;
    logic          ovf_a, exc_a, dchg_a;
    logic          ovf_b, exc_b, dchg_b;
    logic [SW-1:0] flits_a, pkts_a, flits_b, pkts_b;

    int vectors     = 0;
    int miscompares = 0;

    noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up_a ();
    noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) down_a ();
    noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up_b ();
    noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) down_b ();

    noc_credit_link #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(NP),
        .FLIT_BUFFER_DEPTH(DEPTH), .STAT_WIDTH(SW)
    ) dut_a (
        .clk_noc           (clk_noc),
        .rst_n             (rst_n),
        .up                (up_a),
        .down              (down_a),
        .clear_stats       (clear_stats),
        .credits_avail     (credits_a),
        .err_overflow      (ovf_a),
        .err_credit_excess (exc_a),
        .err_dest_change   (dchg_a),
        .flit_count        (flits_a),
        .pkt_count         (pkts_a)
    );

    noc_credit_link #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(0),
        .FLIT_BUFFER_DEPTH(DEPTH), .STAT_WIDTH(SW)
    ) dut_b (
        .clk_noc           (clk_noc),
        .rst_n             (rst_n),
        .up                (up_b),
        .down              (down_b),
        .clear_stats       (clear_stats),
        .credits_avail     (credits_b),
        .err_overflow      (ovf_b),
        .err_credit_excess (exc_b),
        .err_dest_change   (dchg_b),
        .flit_count        (flits_b),
        .pkt_count         (pkts_b)
    );

    // Free-running NoC clock, 10 time units per cycle
    initial begin
        clk_noc = 1'b0;
        forever #5 clk_noc = ~clk_noc;
    end

    function automatic logic [FW-1:0] flitData(input int i);
        logic [31:0] word;
        word = 32'hCAFE_0000 | 32'(i);
        return {4{word}};
    endfunction

    task automatic checkOutput(input string tag, input logic [FW-1:0] actual,
                               input logic [FW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic s, input logic [FW-1:0] d,
                               input logic [DW-1:0] dst, input logic t,
                               input logic c, input logic clr);
        up_a.send      = s;
        up_a.data      = d;
        up_a.dest      = dst;
        up_a.is_tail   = t;
        down_a.credit  = c;
        up_b.send      = s;
        up_b.data      = d;
        up_b.dest      = dst;
        up_b.is_tail   = t;
        down_b.credit  = c;
        clear_stats    = clr;
    endtask

    task automatic stepCycle();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [FW-1:0] d,
                                 input logic [DW-1:0] dst, input logic t,
                                 input logic c, input logic clr);
        driveInputs(s, d, dst, t, c, clr);
        stepCycle();
    endtask

    initial begin
        // ---------------- reset values ----------------
        rst_n = 1'b1;
        driveInputs(0, '0, '0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_send_out",   down_a.send,    0);
        checkOutput("rst_tail_out",   down_a.is_tail, 0);
        checkOutput("rst_data_out",   down_a.data,    0);
        checkOutput("rst_dest_out",   down_a.dest,    0);
        checkOutput("rst_credit_out", up_a.credit,    0);
        checkOutput("rst_credits",    credits_a,      DEPTH);
        checkOutput("rst_flits",      flits_a,        0);
        checkOutput("rst_pkts",       pkts_a,         0);
        checkOutput("rst_ovf",        ovf_a,          0);
        checkOutput("rst_exc",        exc_a,          0);
        checkOutput("rst_dchg",       dchg_a,         0);
        @(negedge clk_noc);
        rst_n = 1'b1;
        stepCycle();

        // ---------------- latency and credit accounting ----------------
        $display("[TB] latency / credit accounting");
        driveInputs(1, flitData(0), 6'h15, 0, 1, 0);
        #1;
        checkOutput("wire_send",   down_b.send, 1);
        checkOutput("wire_data",   down_b.data, flitData(0));
        checkOutput("wire_credit", up_b.credit, 1);
        stepCycle();
        checkOutput("lat_send_early", down_a.send, 0);
        checkOutput("lat_credits0",   credits_a,   3);
        checkOutput("wire_credits0",  credits_b,   4);

        applyStimulus(1, flitData(1), 6'h15, 0, 0, 0);
        checkOutput("lat_send0",     down_a.send,    1);
        checkOutput("lat_data0",     down_a.data,    flitData(0));
        checkOutput("lat_dest0",     down_a.dest,    6'h15);
        checkOutput("lat_tail0",     down_a.is_tail, 0);
        checkOutput("lat_credit_out", up_a.credit,   1);
        checkOutput("lat_credits1",  credits_a,      2);
        checkOutput("wire_credits1", credits_b,      3);

        applyStimulus(1, flitData(2), 6'h15, 0, 0, 0);
        checkOutput("same_cycle_cnt", credits_a,   2);
        checkOutput("lat_data1",      down_a.data, flitData(1));
        checkOutput("credit_pulse",   up_a.credit, 0);

        applyStimulus(1, flitData(3), 6'h15, 0, 0, 0);
        checkOutput("lat_credits3", credits_a,   1);
        checkOutput("lat_data2",    down_a.data, flitData(2));

        applyStimulus(1, flitData(4), 6'h15, 1, 0, 0);
        checkOutput("lat_credits4", credits_a,      0);
        checkOutput("lat_data3",    down_a.data,    flitData(3));
        checkOutput("lat_tail3",    down_a.is_tail, 0);
        checkOutput("lat_no_ovf",   ovf_a,          0);

        applyStimulus(0, '0, '0, 0, 1, 0);
        checkOutput("lat_send4",  down_a.send,    1);
        checkOutput("lat_data4",  down_a.data,    flitData(4));
        checkOutput("lat_tail4",  down_a.is_tail, 1);
        checkOutput("pkt_flits",  flits_a,        5);
        checkOutput("pkt_pkts",   pkts_a,         1);
        checkOutput("pkt_dchg",   dchg_a,         0);

        applyStimulus(0, '0, '0, 0, 1, 0);
        checkOutput("lat_send_idle", down_a.send, 0);
        checkOutput("ret_credit_out", up_a.credit, 1);
        checkOutput("ret_credits0",  credits_a,   0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, '0, '0, 0, (i < 2), 0);
            checkOutput($sformatf("ret_credits%0d", i + 1), credits_a, i + 1);
        end
        checkOutput("ret_no_exc", exc_a, 0);
        checkOutput("ret_no_ovf", ovf_a, 0);

        // ---------------- overflow and excess ----------------
        $display("[TB] overflow / excess");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, flitData(10 + i), 6'h00, 1, 0, 0);
            checkOutput($sformatf("ovf_credits%0d", i), credits_a, (i < 4) ? 3 - i : 0);
            checkOutput($sformatf("ovf_flag%0d", i), ovf_a, (i == 4));
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, '0, '0, 0, (i < 5), 0);
            checkOutput($sformatf("exc_credits%0d", i), credits_a, (i < 2) ? 0 : ((i < 6) ? i - 1 : 4));
            checkOutput($sformatf("exc_flag%0d", i), exc_a, (i == 6));
        end
        applyStimulus(0, '0, '0, 0, 0, 0);
        checkOutput("sticky_ovf", ovf_a,   1);
        checkOutput("sticky_exc", exc_a,   1);
        checkOutput("ovf_flits",  flits_a, 10);
        checkOutput("ovf_pkts",   pkts_a,  6);

        applyStimulus(0, '0, '0, 0, 0, 1);
        checkOutput("clr_ovf",     ovf_a,     0);
        checkOutput("clr_exc",     exc_a,     0);
        checkOutput("clr_flits",   flits_a,   0);
        checkOutput("clr_pkts",    pkts_a,    0);
        checkOutput("clr_credits", credits_a, 4);

        // ---------------- framing ----------------
        $display("[TB] framing");
        applyStimulus(1, flitData(20), 6'h03, 0, 1, 0);
        checkOutput("frm_head",   dchg_a, 0);
        applyStimulus(1, flitData(21), 6'h07, 0, 1, 0);
        checkOutput("frm_change", dchg_a, 1);
        applyStimulus(1, flitData(22), 6'h03, 1, 1, 0);
        checkOutput("frm_sticky", dchg_a, 1);
        applyStimulus(0, '0, '0, 0, 0, 1);
        checkOutput("frm_clear",  dchg_a, 0);
        applyStimulus(1, flitData(23), 6'h09, 1, 1, 0);
        checkOutput("frm_single", dchg_a, 0);
        applyStimulus(1, flitData(24), 6'h0C, 0, 1, 0);
        checkOutput("frm_new_head", dchg_a, 0);
        applyStimulus(1, flitData(25), 6'h0C, 1, 1, 0);
        checkOutput("frm_new_tail", dchg_a, 0);
        checkOutput("frm_flits",    flits_a, 3);
        checkOutput("frm_pkts",     pkts_a,  2);
        applyStimulus(0, '0, '0, 0, 0, 0);
        applyStimulus(0, '0, '0, 0, 0, 0);
        checkOutput("frm_credits", credits_a, 4);
        checkOutput("frm_no_ovf",  ovf_a,     0);
        checkOutput("frm_no_exc",  exc_a,     0);

        // ---------------- clear_stats collision ----------------
        $display("[TB] clear collision");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, flitData(30 + i), 6'h01, (i < 5), 1, 0);
        end
        checkOutput("col_pre_flits", flits_a, 9);
        checkOutput("col_pre_pkts",  pkts_a,  7);
        applyStimulus(1, flitData(40), 6'h02, 1, 1, 1);
        checkOutput("col_flits", flits_a, 0);
        checkOutput("col_pkts",  pkts_a,  0);
        checkOutput("col_dchg",  dchg_a,  0);
        checkOutput("col_ovf",   ovf_a,   0);
        checkOutput("col_exc",   exc_a,   0);
        applyStimulus(1, flitData(41), 6'h05, 1, 1, 0);
        checkOutput("col_next_flits", flits_a, 1);
        checkOutput("col_next_pkts",  pkts_a,  1);
        checkOutput("col_next_dchg",  dchg_a,  0);
        applyStimulus(0, '0, '0, 0, 0, 0);
        applyStimulus(0, '0, '0, 0, 0, 0);
        checkOutput("col_credits", credits_a, 4);

        // ---------------- reset mid-operation ----------------
        $display("[TB] reset mid-packet");
        applyStimulus(1, flitData(50), 6'h15, 0, 1, 0);
        applyStimulus(1, flitData(51), 6'h15, 0, 0, 0);
        checkOutput("mid_send_out",   down_a.send, 1);
        checkOutput("mid_data_out",   down_a.data, flitData(50));
        checkOutput("mid_credit_out", up_a.credit, 1);
        checkOutput("mid_credits",    credits_a,   2);
        driveInputs(0, '0, '0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_send_out",   down_a.send, 0);
        checkOutput("arst_data_out",   down_a.data, 0);
        checkOutput("arst_credit_out", up_a.credit, 0);
        checkOutput("arst_credits",    credits_a,   4);
        checkOutput("arst_flits",      flits_a,     0);
        @(negedge clk_noc);
        rst_n = 1'b1;
        stepCycle();
        applyStimulus(1, flitData(60), 6'h03, 0, 0, 0);
        checkOutput("post_flush", down_a.send, 0);
        applyStimulus(1, flitData(61), 6'h03, 1, 0, 0);
        checkOutput("post_send0", down_a.send, 1);
        checkOutput("post_data0", down_a.data, flitData(60));
        checkOutput("post_dchg",  dchg_a,      0);
        applyStimulus(0, '0, '0, 0, 0, 0);
        checkOutput("post_data1",   down_a.data,    flitData(61));
        checkOutput("post_tail1",   down_a.is_tail, 1);
        checkOutput("post_flits",   flits_a,        2);
        checkOutput("post_pkts",    pkts_a,         1);
        checkOutput("post_dchg2",   dchg_a,         0);
        checkOutput("post_credits", credits_a,      2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
